// File: rtl/fir_seq_mac.sv
// Time-multiplexed FIR: one signed multiplier and one accumulator shared by all taps.
// Shadow/active coefficient banks with deferred commit, round/saturate output, flush.
module fir_seq_mac #(
    parameter int unsigned D_W   = 16,
    parameter int unsigned C_W   = 12,
    parameter int unsigned TAPS  = 32,
    parameter int unsigned OUT_W = 12,
    parameter int unsigned SHIFT = 12
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic signed [D_W-1:0]       fir_in,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [OUT_W-1:0]     fir_out,
    output logic                        out_valid,
    output logic                        sat,
    input  logic                        coeff_we,
    input  logic [$clog2(TAPS)-1:0]     coeff_addr,
    input  logic signed [C_W-1:0]       coeff_data,
    input  logic                        coeff_commit,
    input  logic                        clear
);

    localparam int unsigned A_W    = $clog2(TAPS);
    localparam int unsigned P_W    = D_W + C_W;
    localparam int unsigned ACC_W  = D_W + C_W + A_W;
    localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [ACC_W:0] RND =
        (SHIFT > 0) ? ({{ACC_W{1'b0}}, 1'b1} << RND_SH) : '0;
    localparam logic signed [ACC_W:0] MAX_O =
        {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] MIN_O =
        {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StAccum, StRound} state_t;

    state_t                   r_state;
    logic signed [D_W-1:0]    r_x      [TAPS];
    logic signed [C_W-1:0]    r_shadow [TAPS];
    logic signed [C_W-1:0]    r_active [TAPS];
    logic signed [ACC_W-1:0]  r_acc;
    logic [A_W-1:0]           r_idx;
    logic                     r_pending;
    logic signed [OUT_W-1:0]  r_out;
    logic                     r_valid;
    logic                     r_sat;

    logic signed [C_W-1:0]    w_shadow_nxt [TAPS];
    logic                     w_commit;
    logic signed [P_W-1:0]    w_xe;
    logic signed [P_W-1:0]    w_he;
    logic signed [P_W-1:0]    w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W:0]    w_acc_ext;
    logic signed [ACC_W:0]    w_rnd;
    logic signed [ACC_W:0]    w_shifted;

    // Shadow contents as of this edge, so a same-cycle write is seen by a commit.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if (coeff_we && (32'(coeff_addr) < TAPS)) begin
            w_shadow_nxt[coeff_addr] = coeff_data;
        end
    end

    assign w_commit   = (r_state == StIdle) && (coeff_commit || r_pending);
    assign w_xe       = {{C_W{r_x[r_idx][D_W-1]}}, r_x[r_idx]};
    assign w_he       = {{D_W{r_active[r_idx][C_W-1]}}, r_active[r_idx]};
    assign w_prod     = w_xe * w_he;
    assign w_prod_ext = {{A_W{w_prod[P_W-1]}}, w_prod};
    assign w_acc_ext  = {r_acc[ACC_W-1], r_acc};
    assign w_rnd      = w_acc_ext + $signed(RND);
    assign w_shifted  = w_rnd >>> SHIFT;

    assign in_ready  = (r_state == StIdle) && !reset;
    assign fir_out   = r_out;
    assign out_valid = r_valid;
    assign sat       = r_sat;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= StIdle;
            r_acc     <= '0;
            r_idx     <= '0;
            r_pending <= 1'b0;
            r_out     <= '0;
            r_valid   <= 1'b0;
            r_sat     <= 1'b0;
            for (int unsigned k = 0; k < TAPS; k++) begin
                r_x[k]      <= '0;
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
        end else begin
            r_shadow <= w_shadow_nxt;
            if (w_commit) begin
                r_active <= w_shadow_nxt;
            end
            if (r_state != StIdle) begin
                if (coeff_commit) r_pending <= 1'b1;
            end else begin
                r_pending <= 1'b0;
            end

            r_valid <= 1'b0;
            if (clear) begin
                r_state <= StIdle;
                r_acc   <= '0;
                r_idx   <= '0;
                for (int unsigned k = 0; k < TAPS; k++) r_x[k] <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (in_valid) begin
                            r_x[0] <= fir_in;
                            for (int unsigned k = 1; k < TAPS; k++) r_x[k] <= r_x[k-1];
                            r_acc   <= '0;
                            r_idx   <= '0;
                            r_state <= StAccum;
                        end
                    end
                    StAccum: begin
                        r_acc <= r_acc + w_prod_ext;
                        r_idx <= r_idx + 1'b1;
                        if (r_idx == A_W'(TAPS - 1)) r_state <= StRound;
                    end
                    StRound: begin
                        if (w_shifted > MAX_O) begin
                            r_out <= MAX_O[OUT_W-1:0];
                            r_sat <= 1'b1;
                        end else if (w_shifted < MIN_O) begin
                            r_out <= MIN_O[OUT_W-1:0];
                            r_sat <= 1'b1;
                        end else begin
                            r_out <= w_shifted[OUT_W-1:0];
                            r_sat <= 1'b0;
                        end
                        r_valid <= 1'b1;
                        r_state <= StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fir_seq_mac.sv
// Directed bench for fir_seq_mac with TAPS=6, SHIFT=12; expected values hand-computed.
module tb_fir_seq_mac;

    localparam int unsigned D_W   = 16;
    localparam int unsigned C_W   = 12;
    localparam int unsigned TAPS  = 6;
    localparam int unsigned OUT_W = 12;
    localparam int unsigned SHIFT = 12;
    localparam int unsigned A_W   = $clog2(TAPS);
    localparam int          LAT   = TAPS + 2;

    logic                     clock;
    logic                     reset;
    logic signed [D_W-1:0]    fir_in;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [OUT_W-1:0]  fir_out;
    logic                     out_valid;
    logic                     sat;
    logic                     coeff_we;
    logic [A_W-1:0]           coeff_addr;
    logic signed [C_W-1:0]    coeff_data;
    logic                     coeff_commit;
    logic                     clear;

    int n_cmp = 0;
    int n_bad = 0;

    fir_seq_mac #(
        .D_W(D_W), .C_W(C_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(SHIFT)
    ) dut (
        .clock(clock), .reset(reset), .fir_in(fir_in), .in_valid(in_valid),
        .in_ready(in_ready), .fir_out(fir_out), .out_valid(out_valid), .sat(sat),
        .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
        .coeff_commit(coeff_commit), .clear(clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Writes coefficient value v to every tap, or only to tap `only` (others zero) if only >= 0.
    task automatic load_coeffs(input int v, input int only, input bit step);
        for (int k = 0; k < int'(TAPS); k++) begin
            coeff_we   = 1'b1;
            coeff_addr = A_W'(k);
            if (step)            coeff_data = C_W'(k + 1);
            else if (only < 0)   coeff_data = C_W'(v);
            else                 coeff_data = (k == only) ? C_W'(v) : '0;
            tick();
        end
        coeff_we = 1'b0;
    endtask

    task automatic do_commit();
        coeff_commit = 1'b1;
        tick();
        coeff_commit = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic run_sample(input int x, output logic signed [OUT_W-1:0] y,
                              output logic s, output int lat);
        int n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        fir_in   = D_W'(x);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        y = fir_out;
        s = sat;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        n_cmp++; if (fir_out !== '0) begin n_bad++; $display("FAIL reset_out: got %0d want 0", fir_out); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (sat !== 1'b0) begin n_bad++; $display("FAIL reset_sat: got %b want 0", sat); end
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_impulse();
        logic signed [OUT_W-1:0] y;
        logic s;
        int lat;
        load_coeffs(0, -1, 1'b1);
        do_commit();
        for (int i = 0; i <= int'(TAPS); i++) begin
            run_sample((i == 0) ? 4096 : 0, y, s, lat);
            n_cmp++;
            if (y !== OUT_W'((i < int'(TAPS)) ? i + 1 : 0)) begin
                n_bad++;
                $display("FAIL impulse[%0d]: got %0d want %0d", i, y, (i < int'(TAPS)) ? i + 1 : 0);
            end
            n_cmp++;
            if (lat != LAT) begin n_bad++; $display("FAIL impulse_lat[%0d]: got %0d want %0d", i, lat, LAT); end
        end
    endtask

    task automatic test_back_to_back();
        int c = 0;
        int nout = 0;
        int low = 0;
        int times [3];
        logic signed [OUT_W-1:0] outs [3];
        int exp_v [3] = '{1, 3, 6};
        fir_in   = D_W'(4096);
        in_valid = 1'b1;
        while (nout < 3 && c < 100) begin
            tick();
            c++;
            if (!in_ready) low++;
            if (out_valid) begin
                outs[nout]  = fir_out;
                times[nout] = c;
                nout++;
                if (nout == 3) in_valid = 1'b0;
            end
        end
        n_cmp++; if (nout != 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", nout); end
        for (int i = 0; i < nout; i++) begin
            n_cmp++;
            if (times[i] != LAT * (i + 1)) begin
                n_bad++; $display("FAIL b2b_time[%0d]: got %0d want %0d", i, times[i], LAT * (i + 1));
            end
            n_cmp++;
            if (outs[i] !== OUT_W'(exp_v[i])) begin
                n_bad++; $display("FAIL b2b_val[%0d]: got %0d want %0d", i, outs[i], exp_v[i]);
            end
        end
        n_cmp++;
        if (low != 3 * (LAT - 1)) begin n_bad++; $display("FAIL b2b_ready_low: got %0d want %0d", low, 3 * (LAT - 1)); end
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle: got %b want 1", in_ready); end
    endtask

    task automatic test_clear();
        logic signed [OUT_W-1:0] y;
        logic s;
        int lat;
        bit seen = 1'b0;
        fir_in   = D_W'(4096);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        do_clear();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL clear_ready: got %b want 1", in_ready); end
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        n_cmp++; if (seen) begin n_bad++; $display("FAIL clear_no_valid: got 1 want 0"); end
        n_cmp++; if (fir_out !== OUT_W'(6)) begin n_bad++; $display("FAIL clear_hold: got %0d want 6", fir_out); end
        run_sample(4096, y, s, lat);
        n_cmp++; if (y !== OUT_W'(1)) begin n_bad++; $display("FAIL clear_impulse: got %0d want 1", y); end
    endtask

    task automatic test_commit_accum();
        logic signed [OUT_W-1:0] y;
        logic s;
        int lat;
        int n = 0;
        load_coeffs(1, -1, 1'b0);
        do_commit();
        load_coeffs(2, -1, 1'b0);
        do_clear();
        fir_in   = D_W'(4096);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        coeff_commit = 1'b1;
        tick();
        tick();
        coeff_commit = 1'b0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        n_cmp++; if (fir_out !== OUT_W'(1)) begin n_bad++; $display("FAIL commit_old: got %0d want 1", fir_out); end
        run_sample(0, y, s, lat);
        n_cmp++; if (y !== OUT_W'(2)) begin n_bad++; $display("FAIL commit_new: got %0d want 2", y); end
        load_coeffs(3, -1, 1'b0);
        coeff_commit = 1'b1;
        fir_in       = '0;
        in_valid     = 1'b1;
        tick();
        coeff_commit = 1'b0;
        in_valid     = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        n_cmp++; if (fir_out !== OUT_W'(3)) begin n_bad++; $display("FAIL commit_same_cycle: got %0d want 3", fir_out); end
    endtask

    task automatic test_saturation();
        logic signed [OUT_W-1:0] y;
        logic s;
        int lat;
        int xs   [8] = '{32767, -32768, 32752, 32760, -32768, 2048, 2047, -2049};
        int ys   [8] = '{2047, -2048, 2047, 2047, -2048, 1, 0, -1};
        bit ss   [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin load_coeffs(2047, -1, 1'b0); do_commit(); end
            if (i == 2) begin load_coeffs(256, 0, 1'b0); do_commit(); end
            if (i == 5) begin load_coeffs(1, 0, 1'b0); do_commit(); end
            do_clear();
            run_sample(xs[i], y, s, lat);
            n_cmp++;
            if (y !== OUT_W'(ys[i])) begin n_bad++; $display("FAIL sat_val[%0d]: got %0d want %0d", i, y, ys[i]); end
            n_cmp++;
            if (s !== ss[i]) begin n_bad++; $display("FAIL sat_flag[%0d]: got %b want %b", i, s, ss[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic signed [OUT_W-1:0] y;
        logic s;
        int lat;
        do_clear();
        fir_in   = D_W'(4096);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        do_commit();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (fir_out !== '0) begin n_bad++; $display("FAIL rst_mid_out: got %0d want 0", fir_out); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
        run_sample(4096, y, s, lat);
        n_cmp++; if (y !== '0) begin n_bad++; $display("FAIL rst_mid_impulse: got %0d want 0", y); end
        n_cmp++; if (lat != LAT) begin n_bad++; $display("FAIL rst_mid_lat: got %0d want %0d", lat, LAT); end
    endtask

    initial begin
        reset        = 1'b1;
        fir_in       = '0;
        in_valid     = 1'b0;
        coeff_we     = 1'b0;
        coeff_addr   = '0;
        coeff_data   = '0;
        coeff_commit = 1'b0;
        clear        = 1'b0;
        test_reset();
        test_impulse();
        test_back_to_back();
        test_clear();
        test_commit_accum();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
